idex_stage: RTL and testbench

ID/EX pipeline register for the 5-stage RV32I core, including EX-stage operand selection. It latches decoded operands and control from ID and publishes the rs1/rs2/rd/RegWrite fields that the forwarding unit compares. It consumes the ForwardA/ForwardB selects to produce forwarded ALU operands. It also detects load-use hazards, inserts bubbles, and keeps stall/flush performance counters.

---
 rtl/idex_stage.sv | 105 ++++++++++
 tb/tb_idex_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use bubble insertion, WB bypass,
// EX operand forwarding mux and stall/flush performance counters.
module idex_stage #(
    parameter int CTRL_W = 8,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_RegWrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    input  logic [XLEN-1:0]   EXMEM_alu_result,
    input  logic [XLEN-1:0]   MEMWB_wb_data,
    output logic              IDEX_valid,
    output logic              IDEX_RegWrite,
    output logic              IDEX_MemRead,
    output logic              IDEX_MemWrite,
    output logic              IDEX_ALUSrc,
    output logic [4:0]        IDEX_rs1,
    output logic [4:0]        IDEX_rs2,
    output logic [4:0]        IDEX_rd,
    output logic [XLEN-1:0]   IDEX_pc,
    output logic [XLEN-1:0]   IDEX_imm,
    output logic [CTRL_W-1:0] IDEX_ctrl,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_op_b,
    output logic              stall_out,
    output logic [31:0]       luse_cnt,
    output logic [31:0]       flush_cnt
);
    logic            hz;
    logic [XLEN-1:0] rd1_q, rd2_q, rd1_byp, rd2_byp;

    // rs2 is compared even for I-type: a spurious stall is cheaper than decoding format here
    assign hz = IDEX_valid & IDEX_MemRead & (IDEX_rd != 5'd0) &
                ((IDEX_rd == id_rs1) | (IDEX_rd == id_rs2)) & id_valid;
    assign stall_out = hz & ~flush & ~freeze;

    assign rd1_byp = (wb_RegWrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rd1;
    assign rd2_byp = (wb_RegWrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rd2;

    assign ex_op_a       = ForwardA == 2'b01 ? EXMEM_alu_result : ForwardA == 2'b10 ? MEMWB_wb_data : rd1_q;
    assign ex_store_data = ForwardB == 2'b01 ? EXMEM_alu_result : ForwardB == 2'b10 ? MEMWB_wb_data : rd2_q;
    assign ex_op_b       = IDEX_ALUSrc ? IDEX_imm : ex_store_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {IDEX_valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc} <= '0;
            {IDEX_rs1, IDEX_rs2, IDEX_rd} <= '0;
            IDEX_pc   <= '0;
            IDEX_imm  <= '0;
            IDEX_ctrl <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            luse_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush)
                flush_cnt <= flush_cnt + 32'd1;
            if (stall_out)
                luse_cnt <= luse_cnt + 32'd1;
            if (flush || (!freeze && hz)) begin
                {IDEX_valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc} <= '0;
                {IDEX_rs1, IDEX_rs2, IDEX_rd} <= '0;
                IDEX_pc   <= '0;
                IDEX_imm  <= '0;
                IDEX_ctrl <= '0;
                rd1_q     <= '0;
                rd2_q     <= '0;
            end else if (!freeze) begin
                IDEX_valid    <= id_valid;
                IDEX_RegWrite <= id_RegWrite;
                IDEX_MemRead  <= id_MemRead;
                IDEX_MemWrite <= id_MemWrite;
                IDEX_ALUSrc   <= id_ALUSrc;
                IDEX_rs1      <= id_rs1;
                IDEX_rs2      <= id_rs2;
                IDEX_rd       <= id_rd;
                IDEX_pc       <= id_pc;
                IDEX_imm      <= id_imm;
                IDEX_ctrl     <= id_ctrl;
                rd1_q         <= rd1_byp;
                rd2_q         <= rd2_byp;
            end
        end
    end
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: table-driven vectors for idex_stage plus hand sequences for
// freeze hold, counter wrap and asynchronous mid-run reset.
module tb_idex_stage;
    logic        clk = 0;
    logic        rst, flush, freeze, id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc, wb_RegWrite;
    logic [7:0]  id_ctrl;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] EXMEM_alu_result, MEMWB_wb_data;
    logic        IDEX_valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc;
    logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [31:0] IDEX_pc, IDEX_imm, ex_op_a, ex_store_data, ex_op_b, luse_cnt, flush_cnt;
    logic [7:0]  IDEX_ctrl;
    logic        stall_out;
    int          checks = 0, errors = 0;

    idex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_ALUSrc(id_ALUSrc), .id_ctrl(id_ctrl),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .EXMEM_alu_result(EXMEM_alu_result), .MEMWB_wb_data(MEMWB_wb_data),
        .IDEX_valid(IDEX_valid), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_MemWrite(IDEX_MemWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
        .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_pc(IDEX_pc), .IDEX_imm(IDEX_imm), .IDEX_ctrl(IDEX_ctrl),
        .ex_op_a(ex_op_a), .ex_store_data(ex_store_data), .ex_op_b(ex_op_b),
        .stall_out(stall_out), .luse_cnt(luse_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        flush, freeze, v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic        mr, rw, as;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [1:0]  fa, fb;
        logic        e_stall, e_valid;
        logic [4:0]  e_rd;
        logic [31:0] e_a, e_sd, e_b, e_luse, e_fl;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //       fl fz v  rs1 rs2 rd  rd1     rd2      imm    mr rw as wbw wbrd wbd      fa fb  st ev erd e_a      e_sd     e_b      lu fc
        tv[0]  = '{0, 0, 1, 1,  2,  3,  'h11,   'h22,    'h20,  0, 1, 0, 0,  0,   0,       0, 0,  0, 1, 3,  'h11,    'h22,    'h22,    0, 0};
        tv[1]  = '{0, 0, 1, 4,  5,  6,  'h11,   'h33,    'h20,  0, 1, 1, 0,  0,   0,       1, 2,  0, 1, 6,  'h1234,  'hBEEF,  'h20,    0, 0};
        tv[2]  = '{0, 0, 1, 7,  2,  8,  'h11,   'h44,    'h20,  1, 1, 0, 0,  0,   0,       2, 3,  0, 1, 8,  'hBEEF,  'h44,    'h44,    0, 0};
        tv[3]  = '{0, 0, 1, 8,  1,  9,  'h55,   'h66,    'h20,  1, 1, 0, 0,  0,   0,       3, 0,  1, 0, 0,  0,       0,       0,       1, 0};
        tv[4]  = '{0, 0, 1, 8,  1,  9,  'h55,   'h66,    'h20,  1, 1, 0, 0,  0,   0,       2, 0,  0, 1, 9,  'hBEEF,  'h66,    'h66,    1, 0};
        tv[5]  = '{1, 0, 1, 0,  9,  10, 1,      2,       'h20,  0, 1, 0, 0,  0,   0,       0, 0,  0, 0, 0,  0,       0,       0,       1, 1};
        tv[6]  = '{0, 0, 1, 3,  0,  11, 0,      'h77,    'h20,  0, 1, 0, 1,  3,   'hCAFE,  0, 0,  0, 1, 11, 'hCAFE,  'h77,    'h77,    1, 1};
        tv[7]  = '{0, 0, 1, 0,  0,  12, 0,      'h88,    'h20,  0, 1, 0, 1,  0,   'hCAFE,  0, 0,  0, 1, 12, 0,       'h88,    'h88,    1, 1};
        tv[8]  = '{0, 0, 1, 1,  4,  13, 'h99,   0,       'h20,  1, 1, 0, 1,  4,   'hD00D,  0, 0,  0, 1, 13, 'h99,    'hD00D,  'hD00D,  1, 1};
        tv[9]  = '{1, 1, 1, 13, 0,  20, 1,      2,       'h20,  0, 1, 0, 0,  0,   0,       0, 0,  0, 0, 0,  0,       0,       0,       1, 2};
        tv[10] = '{0, 0, 1, 5,  0,  14, 'h5A,   0,       'h20,  1, 1, 0, 0,  5,   'hFFFF,  0, 0,  0, 1, 14, 'h5A,    0,       0,       1, 2};

        rst = 1; flush = 0; freeze = 0; id_valid = 0; id_pc = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
        id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_ALUSrc = 0; id_ctrl = 8'hA5;
        wb_RegWrite = 0; wb_rd = 0; wb_data = 0; ForwardA = 0; ForwardB = 0;
        EXMEM_alu_result = 32'h1234; MEMWB_wb_data = 32'hBEEF;
        repeat (2) @(negedge clk);
        chk("reset valid", IDEX_valid, 0);
        chk("reset rd", IDEX_rd, 0);
        chk("reset luse", luse_cnt, 0);
        chk("reset flush_cnt", flush_cnt, 0);
        chk("reset stall", stall_out, 0);
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            flush = tv[i].flush; freeze = tv[i].freeze; id_valid = tv[i].v;
            id_rs1 = tv[i].rs1; id_rs2 = tv[i].rs2; id_rd = tv[i].rd;
            id_rd1 = tv[i].rd1; id_rd2 = tv[i].rd2; id_imm = tv[i].imm;
            id_MemRead = tv[i].mr; id_RegWrite = tv[i].rw; id_ALUSrc = tv[i].as;
            wb_RegWrite = tv[i].wbw; wb_rd = tv[i].wbrd; wb_data = tv[i].wbd;
            ForwardA = tv[i].fa; ForwardB = tv[i].fb;
            id_pc = 32'h1000 + 32'(i) * 4;
            #1;
            chk($sformatf("v%0d stall", i), stall_out, tv[i].e_stall);
            @(posedge clk); #1;
            chk($sformatf("v%0d valid", i), IDEX_valid, tv[i].e_valid);
            chk($sformatf("v%0d rd", i), IDEX_rd, tv[i].e_rd);
            chk($sformatf("v%0d op_a", i), ex_op_a, tv[i].e_a);
            chk($sformatf("v%0d store_data", i), ex_store_data, tv[i].e_sd);
            chk($sformatf("v%0d op_b", i), ex_op_b, tv[i].e_b);
            chk($sformatf("v%0d luse_cnt", i), luse_cnt, tv[i].e_luse);
            chk($sformatf("v%0d flush_cnt", i), flush_cnt, tv[i].e_fl);
        end

        // freeze holds the lw x14 in EX while ID carries a dependent instruction
        @(negedge clk);
        flush = 0; freeze = 1; id_valid = 1; id_rs1 = 14; id_rs2 = 0; id_rd = 21;
        id_rd1 = 32'hFFFF; id_pc = 32'h3000; id_MemRead = 0; wb_RegWrite = 0;
        ForwardA = 0; ForwardB = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("freeze%0d stall", k), stall_out, 0);
            @(posedge clk); #1;
            chk($sformatf("freeze%0d rd", k), IDEX_rd, 14);
            chk($sformatf("freeze%0d pc", k), IDEX_pc, 32'h1028);
            chk($sformatf("freeze%0d valid", k), IDEX_valid, 1);
            chk($sformatf("freeze%0d op_a", k), ex_op_a, 32'h5A);
            chk($sformatf("freeze%0d luse", k), luse_cnt, 1);
            @(negedge clk);
        end
        freeze = 0;
        #1;
        chk("unfreeze stall", stall_out, 1);
        @(posedge clk); #1;
        chk("unfreeze bubble valid", IDEX_valid, 0);
        chk("unfreeze bubble rd", IDEX_rd, 0);
        chk("unfreeze luse", luse_cnt, 2);
        @(posedge clk); #1;
        chk("after bubble rs1", IDEX_rs1, 14);
        chk("after bubble rd", IDEX_rd, 21);

        // counter wrap
        @(negedge clk);
        force dut.flush_cnt = 32'hFFFFFFFF;
        #1;
        release dut.flush_cnt;
        #1;
        chk("wrap preset", flush_cnt, 32'hFFFFFFFF);
        flush = 1;
        @(posedge clk); #1;
        chk("wrap flush_cnt", flush_cnt, 0);
        chk("wrap bubble", IDEX_valid, 0);

        // asynchronous reset mid-run
        @(negedge clk);
        flush = 0; id_valid = 1; id_rs1 = 2; id_rd = 7; id_rd1 = 32'h77; id_pc = 32'h2000;
        @(posedge clk); #1;
        chk("pre-reset rd", IDEX_rd, 7);
        #2;
        rst = 1;
        #1;
        chk("async reset valid", IDEX_valid, 0);
        chk("async reset rd", IDEX_rd, 0);
        chk("async reset pc", IDEX_pc, 0);
        chk("async reset ctrl", IDEX_ctrl, 0);
        chk("async reset op_a", ex_op_a, 0);
        chk("async reset luse", luse_cnt, 0);
        chk("async reset flush_cnt", flush_cnt, 0);
        chk("async reset stall", stall_out, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("post-reset valid", IDEX_valid, 1);
        chk("post-reset rd", IDEX_rd, 7);
        chk("post-reset pc", IDEX_pc, 32'h2000);
        chk("post-reset ctrl", IDEX_ctrl, 8'hA5);
        chk("post-reset op_a", ex_op_a, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
